// File: rtl/muc_pkg.sv
// rtl/muc_pkg.sv - shared constants and state type for the dot-product accumulator
package muc_pkg;

  localparam int MUC_N_TERMS   = 4;
  localparam int MUC_P_WIDTH   = 4;
  localparam int MUC_ACC_WIDTH = 8;

  // Clamp limits for the default accumulator width
  localparam logic [MUC_ACC_WIDTH-1:0] MUC_SAT_MAX = {1'b0, {(MUC_ACC_WIDTH-1){1'b1}}};
  localparam logic [MUC_ACC_WIDTH-1:0] MUC_SAT_MIN = {1'b1, {(MUC_ACC_WIDTH-1){1'b0}}};

  typedef enum logic {
    ST_ACC  = 1'b0,
    ST_HOLD = 1'b1
  } muc_state_e;

endpackage

// File: rtl/sm_to_tc.sv
// rtl/sm_to_tc.sv - sign-magnitude to two's-complement converter
module sm_to_tc #(
  parameter int P_WIDTH   = 4,
  parameter int ACC_WIDTH = 8
) (
  input  logic [P_WIDTH-1:0]   p_i,
  input  logic                 sign_i,
  output logic [ACC_WIDTH-1:0] term_o
);

  logic [ACC_WIDTH-1:0] mag;

  // Negating zero yields zero, so sign=1 with p=0 maps cleanly to 0
  assign mag    = {{(ACC_WIDTH-P_WIDTH){1'b0}}, p_i};
  assign term_o = sign_i ? (-mag) : mag;

endmodule

// File: rtl/muc_acc.sv
// rtl/muc_acc.sv - saturating dot-product accumulator with valid/ready result port
module muc_acc
  import muc_pkg::*;
#(
  parameter int N_TERMS   = MUC_N_TERMS,
  parameter int P_WIDTH   = MUC_P_WIDTH,
  parameter int ACC_WIDTH = MUC_ACC_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [P_WIDTH-1:0]   p,
  input  logic                 sign,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] acc_out,
  output logic                 sat
);

  localparam int CNT_W = (N_TERMS > 1) ? $clog2(N_TERMS) : 1;
  localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(N_TERMS - 1);
  localparam logic [ACC_WIDTH-1:0] SAT_MAX  = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic [ACC_WIDTH-1:0] SAT_MIN  = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  muc_state_e           state_q, state_d;
  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [ACC_WIDTH-1:0] acc_out_q, acc_out_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 sat_q, sat_d;

  logic [ACC_WIDTH-1:0] term;
  logic [ACC_WIDTH:0]   sum_w;
  logic [ACC_WIDTH-1:0] sum_clamped;
  logic                 sum_ovf;

  sm_to_tc #(
    .P_WIDTH   (P_WIDTH),
    .ACC_WIDTH (ACC_WIDTH)
  ) u_sm_to_tc (
    .p_i    (p),
    .sign_i (sign),
    .term_o (term)
  );

  // One extra bit holds the exact sum; disagreeing top bits mean overflow
  always_comb begin
    sum_w       = {acc_q[ACC_WIDTH-1], acc_q} + {term[ACC_WIDTH-1], term};
    sum_ovf     = sum_w[ACC_WIDTH] ^ sum_w[ACC_WIDTH-1];
    sum_clamped = sum_w[ACC_WIDTH-1:0];
    if (sum_ovf) begin
      sum_clamped = sum_w[ACC_WIDTH] ? SAT_MIN : SAT_MAX;
    end
  end

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    acc_out_d = acc_out_q;
    cnt_d     = cnt_q;
    sat_d     = sat_q;
    case (state_q)
      ST_ACC: begin
        if (flush) begin
          acc_d = '0;
          cnt_d = '0;
          sat_d = 1'b0;
        end else if (in_valid) begin
          acc_d = sum_clamped;
          sat_d = sat_q | sum_ovf;
          if (cnt_q == CNT_LAST) begin
            cnt_d     = '0;
            acc_out_d = sum_clamped;
            state_d   = ST_HOLD;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: begin
        if (flush || out_ready) begin
          acc_d   = '0;
          sat_d   = 1'b0;
          state_d = ST_ACC;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_ACC;
      acc_q     <= '0;
      acc_out_q <= '0;
      cnt_q     <= '0;
      sat_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      acc_out_q <= acc_out_d;
      cnt_q     <= cnt_d;
      sat_q     <= sat_d;
    end
  end

  assign in_ready  = rst_n && (state_q == ST_ACC);
  assign out_valid = (state_q == ST_HOLD);
  assign acc_out   = acc_out_q;
  assign sat       = sat_q;

endmodule

// File: tb/tb_muc_acc.sv
// tb/tb_muc_acc.sv - directed self-checking bench for muc_acc (8-bit and 6-bit instances)
module tb_muc_acc;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       flush;
  logic       in_valid;
  logic [3:0] p;
  logic       sign;
  logic       out_ready;

  logic       in_ready, out_valid, sat;
  logic [7:0] acc_out;
  logic       s_in_ready, s_out_valid, s_sat;
  logic [5:0] s_acc_out;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  muc_acc #(.N_TERMS(4), .P_WIDTH(4), .ACC_WIDTH(8)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .p         (p),
    .sign      (sign),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .acc_out   (acc_out),
    .sat       (sat)
  );

  muc_acc #(.N_TERMS(4), .P_WIDTH(4), .ACC_WIDTH(6)) u_sat (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (s_in_ready),
    .p         (p),
    .sign      (sign),
    .out_valid (s_out_valid),
    .out_ready (out_ready),
    .acc_out   (s_acc_out),
    .sat       (s_sat)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_block(input logic [3:0] pv [4], input logic sv [4]);
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      p        = pv[i];
      sign     = sv[i];
      step();
    end
    in_valid = 1'b0;
  endtask

  task automatic send_same(input logic [3:0] pv, input logic sv);
    logic [3:0] pa [4];
    logic       sa [4];
    for (int i = 0; i < 4; i++) begin
      pa[i] = pv;
      sa[i] = sv;
    end
    send_block(pa, sa);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; p = '0; sign = 1'b0; out_ready = 1'b1;
    step(); step();
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || acc_out !== 8'd0 || sat !== 1'b0) begin
      failures++;
      $display("FAIL reset_outputs: in_ready=%b out_valid=%b acc_out=%h sat=%b, want 0 0 00 0",
               in_ready, out_valid, acc_out, sat);
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_release_ready: got %b want 1", in_ready);
    end
  endtask

  task automatic test_basic();
    logic [3:0] pv [4];
    logic       sv [4];
    pv = '{4'd3, 4'd9, 4'd9, 4'd1};
    sv = '{1'b0, 1'b1, 1'b0, 1'b0};
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; p = pv[i]; sign = sv[i];
      step();
    end
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL basic_early_valid: out_valid=%b want 0 after 3 terms", out_valid);
    end
    p = pv[3]; sign = sv[3];
    step();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || acc_out !== 8'd4 || sat !== 1'b0) begin
      failures++;
      $display("FAIL basic_result: out_valid=%b acc_out=%h sat=%b want 1 04 0", out_valid, acc_out, sat);
    end
    step();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL basic_pulse: out_valid=%b in_ready=%b want 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_backpressure();
    logic [3:0] pv [4];
    logic       sv [4];
    pv = '{4'd3, 4'd9, 4'd9, 4'd1};
    sv = '{1'b0, 1'b1, 1'b0, 1'b0};
    out_ready = 1'b0;
    send_block(pv, sv);
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1; p = 4'd7; sign = 1'b0;
      step();
      checks++;
      if (out_valid !== 1'b1 || acc_out !== 8'd4 || in_ready !== 1'b0) begin
        failures++;
        $display("FAIL bp_hold_%0d: out_valid=%b acc_out=%h in_ready=%b want 1 04 0",
                 c, out_valid, acc_out, in_ready);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL bp_release: out_valid=%b in_ready=%b want 0 1", out_valid, in_ready);
    end
    send_same(4'd1, 1'b0);
    checks++;
    if (out_valid !== 1'b1 || acc_out !== 8'd4) begin
      failures++;
      $display("FAIL bp_next_block: out_valid=%b acc_out=%h want 1 04", out_valid, acc_out);
    end
    step();
  endtask

  task automatic test_saturation();
    out_ready = 1'b1;
    send_same(4'd15, 1'b0);
    checks++;
    if (s_out_valid !== 1'b1 || s_acc_out !== 6'd31 || s_sat !== 1'b1) begin
      failures++;
      $display("FAIL sat_pos: valid=%b acc_out=%h sat=%b want 1 1f 1", s_out_valid, s_acc_out, s_sat);
    end
    checks++;
    if (acc_out !== 8'd60 || sat !== 1'b0) begin
      failures++;
      $display("FAIL sat_pos_wide: acc_out=%h sat=%b want 3c 0", acc_out, sat);
    end
    step();
    send_same(4'd15, 1'b1);
    checks++;
    if (s_out_valid !== 1'b1 || s_acc_out !== 6'h20 || s_sat !== 1'b1) begin
      failures++;
      $display("FAIL sat_neg: valid=%b acc_out=%h sat=%b want 1 20 1", s_out_valid, s_acc_out, s_sat);
    end
    checks++;
    if (acc_out !== 8'hC4 || sat !== 1'b0) begin
      failures++;
      $display("FAIL sat_neg_wide: acc_out=%h sat=%b want c4 0", acc_out, sat);
    end
    step();
    send_same(4'd1, 1'b0);
    checks++;
    if (s_acc_out !== 6'd4 || s_sat !== 1'b0) begin
      failures++;
      $display("FAIL sat_clear: acc_out=%h sat=%b want 04 0", s_acc_out, s_sat);
    end
    step();
  endtask

  task automatic test_neg_zero();
    logic [3:0] pv [4];
    logic       sv [4];
    pv = '{4'd0, 4'd3, 4'd0, 4'd2};
    sv = '{1'b1, 1'b1, 1'b0, 1'b0};
    out_ready = 1'b1;
    send_block(pv, sv);
    checks++;
    if (out_valid !== 1'b1 || acc_out !== 8'hFF || sat !== 1'b0) begin
      failures++;
      $display("FAIL neg_zero_mix: valid=%b acc_out=%h sat=%b want 1 ff 0", out_valid, acc_out, sat);
    end
    step();
  endtask

  task automatic test_flush();
    out_ready = 1'b1;
    in_valid = 1'b1; p = 4'd5; sign = 1'b0;
    step(); step();
    flush = 1'b1; p = 4'd7;
    step();
    flush = 1'b0; in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL flush_acc_state: out_valid=%b in_ready=%b want 0 1", out_valid, in_ready);
    end
    send_same(4'd1, 1'b0);
    checks++;
    if (out_valid !== 1'b1 || acc_out !== 8'd4) begin
      failures++;
      $display("FAIL flush_next_block: valid=%b acc_out=%h want 1 04", out_valid, acc_out);
    end
    step();
    out_ready = 1'b0;
    send_same(4'd1, 1'b0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL flush_hold: out_valid=%b in_ready=%b want 0 1", out_valid, in_ready);
    end
    out_ready = 1'b1;
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b1;
    in_valid = 1'b1; p = 4'd1; sign = 1'b0;
    step(); step();
    in_valid = 1'b0;
    rst_n = 1'b0;
    step();
    checks++;
    if (out_valid !== 1'b0 || acc_out !== 8'd0 || sat !== 1'b0 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid: valid=%b acc_out=%h sat=%b in_ready=%b want 0 00 0 0",
               out_valid, acc_out, sat, in_ready);
    end
    rst_n = 1'b1;
    send_same(4'd2, 1'b0);
    checks++;
    if (out_valid !== 1'b1 || acc_out !== 8'd8 || sat !== 1'b0) begin
      failures++;
      $display("FAIL reset_next_block: valid=%b acc_out=%h sat=%b want 1 08 0", out_valid, acc_out, sat);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_saturation();
    test_neg_zero();
    test_flush();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
